// File: rtl/cla_pkg.sv
// Shared types for the slice-serial carry-lookahead adder: slice width,
// FSM states and the propagate/generate pair.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Used for one slice's group P/G and for the running word-level P/G.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

endpackage

// File: rtl/cla4_lookahead.sv
// Purely combinational 4-bit lookahead carry unit. It produces the internal
// carries plus the slice group propagate/generate.
module cla4_lookahead
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] p,
    input  logic [SLICE_W-1:0] g,
    input  logic               c0,
    output logic [4:1]         c,
    output logic               pg,
    output logic               gg
);

    assign pg = &p;
    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

    // Fully expanded, so every carry is two gate levels deep from p/g/c0.
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = gg | (pg & c0);

endmodule

// File: rtl/cla_slice_adder.sv
// Multi-cycle CLA adder that resolves one 4-bit slice per clock, chaining the
// slice carry through a register. It uses a start/done handshake.
module cla_slice_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int N  = WIDTH / SLICE_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("cla_slice_adder: WIDTH must be a non-zero multiple of 4");
        end
    endgenerate

    state_e                        state_q, state_d;
    logic [N-1:0][SLICE_W-1:0]     a_q, a_d, b_q, b_d;
    logic [N-1:0][SLICE_W-1:0]     sum_w_q, sum_w_d;
    logic [N-1:0][SLICE_W-1:0]     sum_q, sum_d;
    logic [KW-1:0]                 k_q, k_d;
    logic                          c_q, c_d;
    logic                          cout_q, cout_d;
    logic                          ovf_q, ovf_d;
    pg_t                           run_q, run_d;
    pg_t                           grp_q, grp_d;

    logic [SLICE_W-1:0]            p_s, g_s, s_s;
    logic [4:1]                    c_s;
    logic                          pg_s, gg_s;

    assign p_s = a_q[k_q] ^ b_q[k_q];
    assign g_s = a_q[k_q] & b_q[k_q];

    cla4_lookahead u_la (
        .p  (p_s),
        .g  (g_s),
        .c0 (c_q),
        .c  (c_s),
        .pg (pg_s),
        .gg (gg_s)
    );

    assign s_s = p_s ^ {c_s[3:1], c_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        k_d     = k_q;
        sum_w_d = sum_w_q;
        run_d   = run_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        grp_d   = grp_q;
        case (state_q)
            RUN: begin
                sum_w_d[k_q] = s_s;
                c_d          = c_s[4];
                run_d.p      = run_q.p & pg_s;
                run_d.g      = gg_s | (pg_s & run_q.g);
                k_d          = k_q + 1'b1;
                // Results become visible only on the edge that enters DONE.
                if (k_q == KW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = sum_w_d;
                    cout_d  = c_s[4];
                    ovf_d   = c_s[3] ^ c_s[4];
                    grp_d   = run_d;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    k_d     = '0;
                    run_d   = '{p: 1'b1, g: 1'b0};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            sum_w_q <= '0;
            run_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            k_q     <= k_d;
            sum_w_q <= sum_w_d;
            run_q   <= run_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            grp_q   <= grp_d;
        end
    end

    assign ready = (state_q != RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
    assign grp_p = grp_q.p;
    assign grp_g = grp_q.g;

endmodule

// File: tb/tb_cla_slice_adder.sv
// Scoreboard bench for cla_slice_adder: expectations come from plain integer
// arithmetic and are pushed when a request is driven, popped on done.
module tb_cla_slice_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        ready, done, cout, ovf, grp_p, grp_g;
    logic [15:0] sum;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        gp;
        logic        gg;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   failures = 0;

    cla_slice_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .grp_p (grp_p),
        .grp_g (grp_g)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] full;
        logic [15:0] low;
        logic [16:0] gen;
        res_t r;
        full   = {1'b0, x} + {1'b0, y} + 17'(ci);
        low    = {1'b0, x[14:0]} + {1'b0, y[14:0]} + 16'(ci);
        gen    = {1'b0, x} + {1'b0, y};
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = low[15] ^ full[16];
        r.gp   = &(x ^ y);
        r.gg   = gen[16];
        return r;
    endfunction

    function automatic res_t observed();
        return {sum, cout, ovf, grp_p, grp_g};
    endfunction

    function automatic res_t pop_exp();
        res_t r;
        r = '1;
        if (sb.size() != 0) r = sb.pop_front();
        return r;
    endfunction

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = ci;
        sb.push_back(model(x, y, ci));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < maxc);
    endtask

    task automatic test_reset();
        checks++;
        if ({ready, done, observed()} !== {1'b1, 1'b0, 20'h0}) begin
            failures++;
            $display("FAIL reset ready/done/outputs got=%h exp=%h",
                     {ready, done, observed()}, {1'b1, 1'b0, 20'h0});
        end
    endtask

    task automatic test_basic();
        logic [15:0] ta[4] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'hAAAA};
        logic [15:0] tb[4] = '{16'h0001, 16'h0001, 16'h4321, 16'h5555};
        logic        tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        res_t e;
        int   n;
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb[i], tc[i]);
            tick();
            start = 1'b0;
            checks++;
            if (ready !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL basic%0d busy ready=%b done=%b exp ready=0 done=0", i, ready, done);
            end
            wait_done(10, n);
            checks++;
            if (done !== 1'b1 || n != 4) begin
                failures++;
                $display("FAIL basic%0d latency got=%0d edges done=%b exp=4", i, n, done);
            end
            e = pop_exp();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL basic%0d result got=%h exp=%h", i, observed(), e);
            end
            tick();
            checks++;
            if (done !== 1'b0 || ready !== 1'b1 || observed() !== e) begin
                failures++;
                $display("FAIL basic%0d hold done=%b ready=%b got=%h exp=%h", i, done, ready, observed(), e);
            end
        end
    endtask

    task automatic test_random();
        res_t e;
        int   n;
        for (int i = 0; i < 6; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
            tick();
            start = 1'b0;
            wait_done(10, n);
            e = pop_exp();
            checks++;
            if (done !== 1'b1 || n != 4 || observed() !== e) begin
                failures++;
                $display("FAIL random%0d n=%0d done=%b got=%h exp=%h", i, n, done, observed(), e);
            end
        end
    endtask

    task automatic test_ignored_start();
        res_t e;
        int   n;
        int   extra;
        drive(16'h1234, 16'h4321, 1'b1);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10, n);
        e = pop_exp();
        checks++;
        if (done !== 1'b1 || n != 2 || observed() !== e) begin
            failures++;
            $display("FAIL ignored_start n=%0d done=%b got=%h exp=%h", n, done, observed(), e);
        end
        extra = 0;
        repeat (8) begin
            tick();
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignored_start extra_done got=%0d exp=0", extra);
        end
    endtask

    task automatic test_mid_reset();
        res_t e;
        int   n;
        int   extra;
        drive(16'h00FF, 16'h0F01, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        sb.delete();
        #2;
        checks++;
        if ({ready, done, observed()} !== {1'b1, 1'b0, 20'h0}) begin
            failures++;
            $display("FAIL mid_reset state got=%h exp=%h", {ready, done, observed()}, {1'b1, 1'b0, 20'h0});
        end
        #2;
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            tick();
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL mid_reset stray_done got=%0d exp=0", extra);
        end
        drive(16'h0F0F, 16'h7001, 1'b1);
        tick();
        start = 1'b0;
        wait_done(10, n);
        e = pop_exp();
        checks++;
        if (done !== 1'b1 || n != 4 || observed() !== e) begin
            failures++;
            $display("FAIL mid_reset after n=%0d done=%b got=%h exp=%h", n, done, observed(), e);
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   n;
        int   n2;
        drive(16'hFFFF, 16'h0001, 1'b0);
        tick();
        drive(16'h0F0F, 16'h00F1, 1'b0);
        wait_done(10, n);
        e = pop_exp();
        checks++;
        if (done !== 1'b1 || n != 4 || observed() !== e) begin
            failures++;
            $display("FAIL b2b first n=%0d done=%b got=%h exp=%h", n, done, observed(), e);
        end
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b accept done=%b ready=%b exp done=0 ready=0", done, ready);
        end
        wait_done(10, n2);
        e = pop_exp();
        checks++;
        if (done !== 1'b1 || n2 + 1 != 5 || observed() !== e || e.sum !== 16'h1000) begin
            failures++;
            $display("FAIL b2b second gap=%0d done=%b got=%h exp=%h", n2 + 1, done, observed(), e);
        end
        tick();
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_random();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
